// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 0x55/CMD/ADDR/DATA[/SUM] byte frames from the UART receiver into held read/write requests.
// Define UART_CMD_CHECKSUM_EN to enable the trailing XOR checksum byte (5-byte frames).
module uart_cmd_parser #(
    parameter int unsigned CLK_FREQ   = 24000000,
    parameter int unsigned TIMEOUT_MS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_wr,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_wdata,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int unsigned CNT_W       = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] HDR_BYTE = 8'h55;
    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD = 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [1:0] ERR_CHKSUM  = 2'd2;
`endif
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
`ifdef UART_CMD_CHECKSUM_EN
        GET_SUM,
`endif
        HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wr_q, wr_nxt;
    logic [7:0]       addr_q, addr_nxt;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       data_q, data_nxt;
    logic [7:0]       sum_exp;
`endif
    logic             valid_nxt;
    logic             out_wr_nxt;
    logic [7:0]       out_addr_nxt;
    logic [7:0]       out_wdata_nxt;
    logic             err_nxt;
    logic [1:0]       code_nxt;
    logic             in_frame;

    // Frame sequencing, timeout and output/next-register selection
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = '0;
        wr_nxt        = wr_q;
        addr_nxt      = addr_q;
`ifdef UART_CMD_CHECKSUM_EN
        data_nxt      = data_q;
        sum_exp       = (wr_q ? CMD_WR : CMD_RD) ^ addr_q ^ data_q;
`endif
        valid_nxt     = 1'b0;
        out_wr_nxt    = cmd_wr;
        out_addr_nxt  = cmd_addr;
        out_wdata_nxt = cmd_wdata;
        err_nxt       = 1'b0;
        code_nxt      = ERR_OVERRUN;
        in_frame      = (state != IDLE) && (state != HOLD);

        case (state)
            IDLE: begin
                if (rx_valid && rx_byte == HDR_BYTE) state_nxt = GET_CMD;
            end
            GET_CMD: begin
                if (rx_valid) begin
                    if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                        wr_nxt    = (rx_byte == CMD_WR);
                        state_nxt = GET_ADDR;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_BAD_CMD;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addr_nxt  = rx_byte;
                    state_nxt = GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
                    data_nxt      = rx_byte;
                    state_nxt     = GET_SUM;
`else
                    out_wr_nxt    = wr_q;
                    out_addr_nxt  = addr_q;
                    out_wdata_nxt = rx_byte;
                    state_nxt     = HOLD;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            GET_SUM: begin
                if (rx_valid) begin
                    if (rx_byte == sum_exp) begin
                        out_wr_nxt    = wr_q;
                        out_addr_nxt  = addr_q;
                        out_wdata_nxt = data_q;
                        state_nxt     = HOLD;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_CHKSUM;
                    end
                end
            end
`endif
            HOLD: begin
                // A byte coinciding with the handshake is treated as the first IDLE byte
                if (cmd_valid && cmd_ready) begin
                    state_nxt = (rx_valid && rx_byte == HDR_BYTE) ? GET_CMD : IDLE;
                end else if (rx_valid) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_OVERRUN;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Inter-byte gap watchdog; an arriving byte always beats the timeout
        if (in_frame && !rx_valid) begin
            if (cnt == CNT_LAST) begin
                state_nxt = IDLE;
                err_nxt   = 1'b1;
                code_nxt  = ERR_TIMEOUT;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end

        valid_nxt = (state_nxt == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            data_q    <= 8'h00;
`endif
            cmd_valid <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= 8'h00;
            cmd_wdata <= 8'h00;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wr_q      <= wr_nxt;
            addr_q    <= addr_nxt;
`ifdef UART_CMD_CHECKSUM_EN
            data_q    <= data_nxt;
`endif
            cmd_valid <= valid_nxt;
            cmd_wr    <= out_wr_nxt;
            cmd_addr  <= out_addr_nxt;
            cmd_wdata <= out_wdata_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser; frames carry a checksum byte when UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_parser;
    localparam int unsigned CLK_FREQ   = 100000;
    localparam int unsigned TIMEOUT_MS = 1;
    localparam int unsigned TOC        = CLK_FREQ / 1000 * TIMEOUT_MS;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       frame_err;
    logic [1:0] err_code;

    int n_cmp  = 0;
    int n_bad  = 0;
    int vcyc   = 0;
    int hs     = 0;
    int errs   = 0;

    uart_cmd_parser #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (cmd_valid) vcyc++;
        if (cmd_valid && cmd_ready) hs++;
        if (frame_err) errs++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        send_byte(8'h55);
        send_byte(c);
        send_byte(a);
        send_byte(d);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(c ^ a ^ d);
`endif
    endtask

    task automatic check_cmd(input string tag, input logic wr, input logic [7:0] a, input logic [7:0] d);
        check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd1);
        check_eq({tag, "_wr"},    32'(cmd_wr),    32'(wr));
        check_eq({tag, "_addr"},  32'(cmd_addr),  32'(a));
        check_eq({tag, "_wdata"}, 32'(cmd_wdata), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v0, h0, e0, n;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_wr",    32'(cmd_wr),    32'd0);
        check_eq("rst_addr",  32'(cmd_addr),  32'd0);
        check_eq("rst_wdata", 32'(cmd_wdata), 32'd0);
        check_eq("rst_err",   32'(frame_err), 32'd0);
        check_eq("rst_code",  32'(err_code),  32'd0);
        rst_n = 1'b1;
        tick();

        // Write frame with ready held high: single-cycle request
        cmd_ready = 1'b1;
        v0 = vcyc; h0 = hs; e0 = errs;
        send_frame(8'h01, 8'h80, 8'h12);
        check_cmd("wr1", 1'b1, 8'h80, 8'h12);
        tick();
        check_eq("wr1_valid_drop", 32'(cmd_valid), 32'd0);
        repeat (3) tick();
        check_eq("wr1_vcyc", vcyc - v0, 32'd1);
        check_eq("wr1_hs",   hs - h0,   32'd1);
        check_eq("wr1_errs", errs - e0, 32'd0);

        // Read frame held 21 cycles, overrun byte during hold
        cmd_ready = 1'b0;
        v0 = vcyc; h0 = hs; e0 = errs;
        send_frame(8'h02, 8'h81, 8'h00);
        check_cmd("rd1", 1'b0, 8'h81, 8'h00);
        repeat (10) tick();
        send_byte(8'h55);
        check_eq("ovr_err",   32'(frame_err), 32'd1);
        check_eq("ovr_code",  32'(err_code),  32'd0);
        check_eq("ovr_valid", 32'(cmd_valid), 32'd1);
        check_eq("ovr_addr",  32'(cmd_addr),  32'h81);
        repeat (9) tick();
        check_eq("ovr_err_clr", 32'(frame_err), 32'd0);
        cmd_ready = 1'b1;
        tick();
        check_eq("rd1_valid_drop", 32'(cmd_valid), 32'd0);
        check_eq("rd1_addr_kept",  32'(cmd_addr),  32'h81);
        repeat (2) tick();
        check_eq("rd1_vcyc", vcyc - v0, 32'd21);
        check_eq("rd1_hs",   hs - h0,   32'd1);
        check_eq("rd1_errs", errs - e0, 32'd1);

        // Checksum mismatch then bad command byte
        v0 = vcyc;
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h80); send_byte(8'h12); send_byte(8'h00);
        check_eq("sum_err",   32'(frame_err), 32'd1);
        check_eq("sum_code",  32'(err_code),  32'd2);
        check_eq("sum_valid", 32'(cmd_valid), 32'd0);
        tick();
        check_eq("sum_err_1cyc", 32'(frame_err), 32'd0);
`endif
        send_byte(8'h55); send_byte(8'h07);
        check_eq("cmd_err",  32'(frame_err), 32'd1);
        check_eq("cmd_code", 32'(err_code),  32'd1);
        tick();
        check_eq("cmd_err_1cyc", 32'(frame_err), 32'd0);
        check_eq("bad_vcyc", vcyc - v0, 32'd0);

        // Inter-byte timeout, then recovery
        e0 = errs;
        send_byte(8'h55); send_byte(8'h01);
        n = 0;
        while (!frame_err && n < 3 * TOC) begin
            tick();
            n++;
        end
        check_eq("to_cycles", n, TOC);
        check_eq("to_code",   32'(err_code), 32'd3);
        tick();
        send_frame(8'h01, 8'h80, 8'h12);
        check_cmd("to_rec", 1'b1, 8'h80, 8'h12);
        tick();

        // Byte arriving in the would-be timeout cycle wins
        send_byte(8'h55); send_byte(8'h01);
        repeat (TOC - 1) tick();
        send_byte(8'h80);
        check_eq("edge_no_to", 32'(frame_err), 32'd0);
        send_byte(8'h34);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h01 ^ 8'h80 ^ 8'h34);
`endif
        check_cmd("edge", 1'b1, 8'h80, 8'h34);
        tick();
        check_eq("to_errs", errs - e0, 32'd1);

        // Garbage before a frame; header arriving with the handshake
        cmd_ready = 1'b0;
        h0 = hs; e0 = errs;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        send_frame(8'h01, 8'h05, 8'hA5);
        check_cmd("gb", 1'b1, 8'h05, 8'hA5);
        repeat (3) tick();
        cmd_ready = 1'b1;
        send_byte(8'h55);
        check_eq("hs55_valid", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b0;
        send_byte(8'h02); send_byte(8'h22); send_byte(8'h33);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h02 ^ 8'h22 ^ 8'h33);
`endif
        check_cmd("hs55", 1'b0, 8'h22, 8'h33);
        cmd_ready = 1'b1;
        tick();
        check_eq("hs55_drop", 32'(cmd_valid), 32'd0);
        repeat (2) tick();
        check_eq("gb_hs",   hs - h0,   32'd2);
        check_eq("gb_errs", errs - e0, 32'd0);

        // Asynchronous reset mid-frame
        cmd_ready = 1'b0;
        send_byte(8'h55); send_byte(8'h01);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(cmd_valid), 32'd0);
        check_eq("arst_wr",    32'(cmd_wr),    32'd0);
        check_eq("arst_addr",  32'(cmd_addr),  32'd0);
        check_eq("arst_wdata", 32'(cmd_wdata), 32'd0);
        check_eq("arst_err",   32'(frame_err), 32'd0);
        check_eq("arst_code",  32'(err_code),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        cmd_ready = 1'b1;
        send_frame(8'h01, 8'h80, 8'h12);
        check_cmd("post_rst", 1'b1, 8'h80, 8'h12);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
